// File: rtl/ble_config_loader_if.sv
// Configuration stream handshake between a bitstream source and ble_config_loader.
// The master drives frame control and serial bits; the slave returns bitready.
interface ble_config_loader_if;
  logic start;
  logic abort;
  logic bitin;
  logic bitvalid;
  logic bitready;

  modport master (
    output start,
    output abort,
    output bitin,
    output bitvalid,
    input  bitready
  );

  modport slave (
    input  start,
    input  abort,
    input  bitin,
    input  bitvalid,
    output bitready
  );
endinterface

// File: rtl/ble_config_loader.sv
// Serial configuration loader for a NUMBLE-BLE fabric: shifts a frame into a shadow
// register and commits it atomically. Define PARITY_CHECK_EN to add a trailing even-parity bit check.
module ble_config_loader #(
  parameter int NUMBLE  = 9,
  parameter int LUTBITS = 16
) (
  input  logic                      clk,
  input  logic                      rstn,
  ble_config_loader_if.slave        cfg_if,
  output logic [NUMBLE*LUTBITS-1:0] lutcfg,
  output logic [NUMBLE-1:0]         selcfg,
  output logic                      cfgbusy,
  output logic                      cfgdone,
  output logic                      cfgerr
);

  localparam int FRAMELEN = NUMBLE * (LUTBITS + 1);
  localparam int CNT_W    = $clog2(FRAMELEN + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAMELEN - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_COMMIT = 2'd2
`ifdef PARITY_CHECK_EN
    , S_CHECK = 2'd3
`endif
  } state_e;

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [FRAMELEN-1:0]       shadow_q, shadow_d;
  logic [NUMBLE*LUTBITS-1:0] lut_q, lut_d;
  logic [NUMBLE-1:0]         sel_q, sel_d;
  logic                      done_q, done_d;
  logic                      bitready_q, bitready_d;
  logic                      busy_q, busy_d;
  logic                      accept;
  logic [NUMBLE*LUTBITS-1:0] frame_lut;
  logic [NUMBLE-1:0]         frame_sel;
`ifdef PARITY_CHECK_EN
  logic                      err_q, err_d;
  logic                      parity_q, parity_d;
`endif

  // The shadow fills as a shift register, so frame bit i ends at shadow_q[i].
  always_comb begin
    frame_lut = '0;
    frame_sel = '0;
    for (int k = 0; k < NUMBLE; k++) begin
      for (int j = 0; j < LUTBITS; j++) begin
        frame_lut[k*LUTBITS + j] = shadow_q[k*(LUTBITS+1) + j];
      end
      frame_sel[k] = shadow_q[k*(LUTBITS+1) + LUTBITS];
    end
  end

  assign accept = cfg_if.bitvalid && bitready_q;

  // NOTE: every _d gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    lut_d    = lut_q;
    sel_d    = sel_q;
    done_d   = done_q;
`ifdef PARITY_CHECK_EN
    err_d    = err_q;
    parity_d = parity_q;
`endif
    if (state_q != S_IDLE && cfg_if.abort) begin
      state_d  = S_IDLE;
      cnt_d    = '0;
      shadow_d = '0;
`ifdef PARITY_CHECK_EN
      parity_d = 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cfg_if.start) begin
            state_d  = S_LOAD;
            cnt_d    = '0;
            shadow_d = '0;
`ifdef PARITY_CHECK_EN
            err_d    = 1'b0;
            parity_d = 1'b0;
`endif
          end
        end
        S_LOAD: begin
          if (accept) begin
            shadow_d = {cfg_if.bitin, shadow_q[FRAMELEN-1:1]};
            cnt_d    = cnt_q + CNT_W'(1);
`ifdef PARITY_CHECK_EN
            parity_d = parity_q ^ cfg_if.bitin;
            if (cnt_q == LAST_IDX) state_d = S_CHECK;
`else
            if (cnt_q == LAST_IDX) state_d = S_COMMIT;
`endif
          end
        end
`ifdef PARITY_CHECK_EN
        S_CHECK: begin
          if (accept) begin
            if (cfg_if.bitin == parity_q) begin
              state_d = S_COMMIT;
            end else begin
              state_d = S_IDLE;
              err_d   = 1'b1;
            end
          end
        end
`endif
        S_COMMIT: begin
          lut_d   = frame_lut;
          sel_d   = frame_sel;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
`ifdef PARITY_CHECK_EN
    bitready_d = (state_d == S_LOAD) || (state_d == S_CHECK);
`else
    bitready_d = (state_d == S_LOAD);
`endif
    busy_d = (state_d != S_IDLE);
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      // NOTE: the shadow is wide but is still cleared so an aborted/reset frame never leaks.
      shadow_q   <= '0;
      lut_q      <= '0;
      sel_q      <= '0;
      done_q     <= 1'b0;
      bitready_q <= 1'b0;
      busy_q     <= 1'b0;
`ifdef PARITY_CHECK_EN
      err_q      <= 1'b0;
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shadow_q   <= shadow_d;
      lut_q      <= lut_d;
      sel_q      <= sel_d;
      done_q     <= done_d;
      bitready_q <= bitready_d;
      busy_q     <= busy_d;
`ifdef PARITY_CHECK_EN
      err_q      <= err_d;
      parity_q   <= parity_d;
`endif
    end
  end

  assign cfg_if.bitready = bitready_q;
  assign lutcfg          = lut_q;
  assign selcfg          = sel_q;
  assign cfgbusy         = busy_q;
  assign cfgdone         = done_q;
`ifdef PARITY_CHECK_EN
  assign cfgerr          = err_q;
`else
  assign cfgerr          = 1'b0;
`endif

endmodule

// File: tb/tb_ble_config_loader.sv
// Scoreboard bench for ble_config_loader: randomized frames against a frame-level model.
// Honors PARITY_CHECK_EN to exercise the parity build as well.
module tb_ble_config_loader;
  localparam int NB = 9;
  localparam int LB = 16;
  localparam int FL = NB * (LB + 1);

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic [NB*LB-1:0] lutcfg;
  logic [NB-1:0]    selcfg;
  logic             cfgbusy, cfgdone, cfgerr;

  ble_config_loader_if cfg_if ();

  ble_config_loader #(.NUMBLE(NB), .LUTBITS(LB)) dut (
    .clk    (clk),
    .rstn   (rstn),
    .cfg_if (cfg_if),
    .lutcfg (lutcfg),
    .selcfg (selcfg),
    .cfgbusy(cfgbusy),
    .cfgdone(cfgdone),
    .cfgerr (cfgerr)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [NB*LB-1:0] lut;
    logic [NB-1:0]    sel;
    logic             done;
    logic             err;
    int               at;
  } exp_t;

  exp_t exp_q[$];

  // Frame-level reference state
  logic [NB*LB-1:0] mdl_lut = '0;
  logic [NB-1:0]    mdl_sel = '0;
  logic             mdl_done = 1'b0;
  logic             mdl_err = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, req);
  endtask

  task automatic decode_frame(input logic [FL-1:0] frame,
                              output logic [NB*LB-1:0] lut, output logic [NB-1:0] sel);
    lut = '0;
    sel = '0;
    for (int i = 0; i < FL; i++) begin
      int ble, pos;
      ble = i / (LB + 1);
      pos = i % (LB + 1);
      if (pos == LB) sel[ble] = frame[i];
      else lut[ble*LB + pos] = frame[i];
    end
  endtask

  task automatic finish_frame(input logic [FL-1:0] frame, input logic par_bit, input int n);
    logic [NB*LB-1:0] l;
    logic [NB-1:0]    s;
`ifdef PARITY_CHECK_EN
    if (par_bit != ($countones(frame) % 2 == 1)) begin
      mdl_err = 1'b1;
      exp_q.push_back('{mdl_lut, mdl_sel, mdl_done, mdl_err, n + 1});
      return;
    end
`endif
    decode_frame(frame, l, s);
    mdl_lut  = l;
    mdl_sel  = s;
    mdl_done = 1'b1;
    exp_q.push_back('{mdl_lut, mdl_sel, mdl_done, mdl_err, n + 2});
  endtask

  // mode: 0 continuous, 1 bitvalid low on odd cycles, 2 random gaps plus stray start pulses
  task automatic run_frame(input logic [FL-1:0] frame, input int mode, input int abort_at,
                           input int rst_at, input logic par_bit, output logic busy_dropped);
    int total, idx, guard, n_cur;
    logic v, rdy, b;
    total = FL;
`ifdef PARITY_CHECK_EN
    total = FL + 1;
`endif
    busy_dropped = 1'b0;
    idx = 0;
    guard = 0;
    @(negedge clk);
    cfg_if.start = 1'b1;
    mdl_err = 1'b0;
    @(negedge clk);
    cfg_if.start = 1'b0;
    check("err_clear_on_start", cfgerr, mdl_err);
    check("busy_after_start", cfgbusy, 1'b1);
    while (idx < total) begin
      guard++;
      if (guard > 4 * total + 50) begin
        check("load_timeout", idx, total);
        break;
      end
      rdy   = cfg_if.bitready;
      n_cur = cyc;
      if (!cfgbusy) busy_dropped = 1'b1;
      b = (idx < FL) ? frame[idx] : par_bit;
      case (mode)
        0:       v = 1'b1;
        1:       v = (n_cur % 2 == 0);
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      if (mode == 2) cfg_if.start = ($urandom_range(0, 7) == 0);
      if (idx == abort_at) begin
        cfg_if.abort    = 1'b1;
        cfg_if.bitvalid = 1'b1;
        cfg_if.bitin    = b;
        exp_q.push_back('{mdl_lut, mdl_sel, mdl_done, mdl_err, n_cur + 1});
        @(negedge clk);
        cfg_if.abort    = 1'b0;
        cfg_if.bitvalid = 1'b0;
        cfg_if.start    = 1'b0;
        return;
      end
      if (idx == rst_at) begin
        rstn            = 1'b0;
        cfg_if.bitvalid = 1'b1;
        cfg_if.bitin    = b;
        @(negedge clk);
        cfg_if.bitvalid = 1'b0;
        cfg_if.start    = 1'b0;
        mdl_lut = '0; mdl_sel = '0; mdl_done = 1'b0; mdl_err = 1'b0;
        check("rst_mid_lut", lutcfg, mdl_lut);
        check("rst_mid_sel", selcfg, mdl_sel);
        check("rst_mid_done", cfgdone, mdl_done);
        check("rst_mid_err", cfgerr, mdl_err);
        check("rst_mid_busy", cfgbusy, 1'b0);
        check("rst_mid_ready", cfg_if.bitready, 1'b0);
        @(negedge clk);
        rstn = 1'b1;
        return;
      end
      cfg_if.bitvalid = v;
      cfg_if.bitin    = b;
      @(posedge clk);
      if (v && rdy) begin
        if (idx == total - 1) finish_frame(frame, par_bit, n_cur);
        idx++;
      end
      @(negedge clk);
    end
    cfg_if.bitvalid = 1'b0;
    cfg_if.start    = 1'b0;
  endtask

  // Monitor: every busy->idle transition outside reset retires one expected outcome
  logic mon_busy_prev = 1'b0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rstn && mon_busy_prev && !cfgbusy) begin
        if (exp_q.size() == 0) begin
          check("frame_end_expected", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          check("sb_lutcfg", lutcfg, e.lut);
          check("sb_selcfg", selcfg, e.sel);
          check("sb_cfgdone", cfgdone, e.done);
          check("sb_cfgerr", cfgerr, e.err);
          check("sb_idle_cycle", cyc, e.at);
        end
      end
      mon_busy_prev = cfgbusy;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d expected end", cyc);
    $fatal(1, "watchdog");
  end

  function automatic logic [FL-1:0] rand_frame();
    logic [FL-1:0] f;
    for (int i = 0; i < FL; i++) f[i] = 1'($urandom_range(0, 1));
    return f;
  endfunction

  initial begin
    logic [FL-1:0] fa, f;
    logic          bd;
    cfg_if.start    = 1'b0;
    cfg_if.abort    = 1'b0;
    cfg_if.bitin    = 1'b0;
    cfg_if.bitvalid = 1'b0;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_lutcfg", lutcfg, mdl_lut);
    check("rst_selcfg", selcfg, mdl_sel);
    check("rst_cfgdone", cfgdone, mdl_done);
    check("rst_cfgerr", cfgerr, mdl_err);
    check("rst_cfgbusy", cfgbusy, 1'b0);
    check("rst_bitready", cfg_if.bitready, 1'b0);
    rstn = 1'b1;

    // LUT0 = A5C3, sel0 = 1, rest zero; continuous then gapped
    fa = '0;
    fa[15:0] = 16'hA5C3;
    fa[16]   = 1'b1;
    run_frame(fa, 0, -1, -1, ^fa, bd);
    @(negedge clk);
    check("a_lut0", lutcfg[15:0], 16'hA5C3);
    check("a_sel", selcfg, 9'h001);
    check("a_done", cfgdone, 1'b1);
    run_frame(fa, 1, -1, -1, ^fa, bd);
    check("gapped_busy_held", bd, 1'b0);
    @(negedge clk);
    check("gapped_lut0", lutcfg[15:0], 16'hA5C3);

    // All-ones commit, then abort after 40 bits
    f = '1;
    run_frame(f, 0, -1, -1, ^f, bd);
    f = rand_frame();
    run_frame(f, 2, 40, -1, ^f, bd);
    check("abort_lut_kept", lutcfg, {(NB*LB){1'b1}});
    check("abort_sel_kept", selcfg, 9'h1FF);
    check("abort_idle", cfgbusy, 1'b0);

    // Abort coinciding with the final frame bit
    f = rand_frame();
    run_frame(f, 0, FL - 1, -1, ^f, bd);

    // Reset after 100 bits, then a clean load
    f = rand_frame();
    run_frame(f, 0, -1, 100, ^f, bd);
    f = rand_frame();
    run_frame(f, 0, -1, -1, ^f, bd);

    for (int t = 0; t < 4; t++) begin
      f = rand_frame();
      run_frame(f, 2, -1, -1, ^f, bd);
    end

`ifdef PARITY_CHECK_EN
    f = '0;
    f[0] = 1'b1; f[7] = 1'b1; f[20] = 1'b1; f[77] = 1'b1; f[152] = 1'b1;
    run_frame(f, 0, -1, -1, 1'b0, bd);
    @(negedge clk);
    check("par_err_set", cfgerr, 1'b1);
    check("par_done_kept", cfgdone, mdl_done);
    check("par_lut_kept", lutcfg, mdl_lut);
    run_frame(f, 2, -1, -1, 1'b1, bd);
    @(negedge clk);
    check("par_commit_sel", selcfg, 9'h100);
    check("par_err_clear", cfgerr, 1'b0);
`endif

    repeat (5) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ble_config_loader.md
BLE_CONFIG_LOADER -- requirements
Module: ble_config_loader

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-low, ports named clk and rstn.
REQ-002 Parameter NUMBLE, default 9, SHALL set the number of BLEs configured (3x3 fabric).
REQ-003 Parameter LUTBITS, default 16, SHALL set the LUT truth-table bits per BLE.
REQ-004 Derived FRAMELEN = NUMBLE*(LUTBITS+1), default 153, SHALL be the number of configuration bits per frame.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rstn  input  1  synchronous active-low reset.
REQ-007 start  input  1  one-cycle request to begin a frame load.
REQ-008 abort  input  1  cancels the load in progress.
REQ-009 bitin  input  1  serial configuration bit.
REQ-010 bitvalid  input  1  bitin is valid this cycle.
REQ-011 bitready  output  1  loader accepts bitin this cycle.
REQ-012 lutcfg  output  NUMBLE*LUTBITS  active LUT contents; BLE k occupies bits [k*LUTBITS +: LUTBITS].
REQ-013 selcfg  output  NUMBLE  active BLE output-mux selects; bit k=0 selects the LUT path, 1 the flip-flop path.
REQ-014 cfgbusy  output  1  high whenever the state is not IDLE.
REQ-015 cfgdone  output  1  sticky; a valid frame has been committed.
REQ-016 cfgerr  output  1  sticky; the last frame failed its check.

Function
REQ-017 States SHALL be IDLE, LOAD, CHECK, COMMIT.
- IDLE->LOAD on start.
- LOAD->CHECK (macro defined) or LOAD->COMMIT (macro undefined) after bit FRAMELEN-1 is accepted.
- CHECK->COMMIT or CHECK->IDLE.
- COMMIT->IDLE.
REQ-018 A bit SHALL be accepted only on a cycle where bitvalid and bitready are both high; bitready SHALL be high only in LOAD, and in CHECK while awaiting the parity bit.
REQ-019 Frame order SHALL be BLE 0 first; per BLE, LUT bits LSB first, then its sel bit.
REQ-020 Accepted bits SHALL go to a shadow register; lutcfg/selcfg SHALL change only on the COMMIT cycle edge, all bits at once.
REQ-021 With the final frame bit accepted in cycle N, the state SHALL be COMMIT in N+1, and the new lutcfg/selcfg with cfgdone=1 SHALL be visible in N+2 (macro undefined).
REQ-022 A bit counter of width clog2(FRAMELEN+1) SHALL reset to 0 on entering LOAD and SHALL never exceed FRAMELEN.
REQ-023 start while cfgbusy SHALL be ignored.
REQ-024 start in IDLE SHALL clear cfgerr; cfgdone SHALL stay unchanged until the next commit.
REQ-025 abort in any non-IDLE state SHALL return to IDLE next cycle, discard the shadow register, and leave lutcfg/selcfg/cfgdone unchanged.
REQ-026 If abort and the final accepted bit occur in the same cycle, abort SHALL win.
REQ-027 A gap in bitvalid SHALL stall the load indefinitely with no timeout.

Reset
REQ-028 With rstn=0 at a clock edge, the block SHALL set state=IDLE, counter=0, shadow=0, lutcfg=0, selcfg=0, cfgdone=0, cfgerr=0, bitready=0, cfgbusy=0.
REQ-029 Reset SHALL take priority over start and abort, including mid-load.

Configuration
REQ-030 Macro PARITY_CHECK_EN defined:
- after FRAMELEN bits, CHECK SHALL accept one more bit, the even parity over the frame;
- on match: COMMIT;
- on mismatch: IDLE, cfgerr=1, active configuration unchanged;
- commit latency becomes N+2 relative to the parity bit.
REQ-031 Macro PARITY_CHECK_EN undefined: the CHECK state and parity logic SHALL be absent, and cfgerr SHALL be constant 0.

Verification
REQ-032 Reset, then a 153-bit frame with LUT0=16'hA5C3, sel0=1, all other bits 0, bitvalid continuous -> lutcfg[15:0]=16'hA5C3, selcfg=9'h001, cfgdone=1 exactly 2 cycles after the last bit.
REQ-033 Same frame with bitvalid low on every odd cycle -> same final outputs; cfgbusy stays high throughout; no bit is lost.
REQ-034 Commit all-ones frame, then start a new frame and assert abort after 40 bits -> lutcfg stays all ones, selcfg=9'h1FF, state IDLE next cycle.
REQ-035 rstn=0 after 100 bits of a load -> all outputs 0 next cycle; a following full frame loads correctly.
REQ-036 PARITY_CHECK_EN defined, frame with 5 ones and parity bit 0 -> cfgerr=1, cfgdone and configuration unchanged; resend with parity 1 -> commit, cfgerr cleared at start.
